rr_arbiter_16: RTL and testbench

//  Round-robin arbiter that shares one downstream resource among N requesters.
//  Its selection core is a rotating priority encoder: highest index first, with the

---
 rtl/rr_arbiter_16.sv | 121 ++++++++++++
 tb/tb_rr_arbiter_16.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// rtl/rr_arbiter_16.sv - 16-way round-robin arbiter with hold timeout and turnaround gap
module rr_arbiter_16 #(
    parameter int N        = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   last_id, last_id_d;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_d;
    logic [N-1:0]       grant_d;
    logic [IDX_W-1:0]   grant_id_d;
    logic               grant_valid_d;
    logic               timeout_d;

    logic [IDX_W-1:0]   start_id;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   win_id;
    logic               win_found;
    logic               owner_release;
    logic               hold_expired;

    // Descending search from the index just below the last winner; the
    // IDX_W-bit subtraction provides the 0 -> N-1 wrap for free.
    always_comb begin
        start_id  = last_id - IDX_W'(1);
        cand      = '0;
        win_id    = '0;
        win_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = start_id - IDX_W'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign owner_release = done || !req[grant_id];
    assign hold_expired  = (hold_cnt == CNT_W'(MAX_HOLD));

    always_comb begin
        state_d       = state;
        last_id_d     = last_id;
        hold_cnt_d    = hold_cnt;
        grant_d       = '0;
        grant_id_d    = '0;
        grant_valid_d = 1'b0;
        timeout_d     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && win_found) begin
                    state_d       = S_GRANT;
                    grant_d       = {{(N-1){1'b0}}, 1'b1} << win_id;
                    grant_id_d    = win_id;
                    grant_valid_d = 1'b1;
                    last_id_d     = win_id;
                    hold_cnt_d    = CNT_W'(1);
                end
            end
            S_GRANT: begin
                if (owner_release || hold_expired) begin
                    // A voluntary release wins over a coincident timeout.
                    state_d    = S_GAP;
                    timeout_d  = !owner_release;
                    hold_cnt_d = '0;
                end else begin
                    grant_d       = grant;
                    grant_id_d    = grant_id;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = hold_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            last_id     <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_d;
            last_id     <= last_id_d;
            hold_cnt    <= hold_cnt_d;
            grant       <= grant_d;
            grant_id    <= grant_id_d;
            grant_valid <= grant_valid_d;
            timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb/tb_rr_arbiter_16.sv - scoreboard bench for rr_arbiter_16
module tb_rr_arbiter_16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        grant_valid;
    logic        timeout;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] exp_q[$];
    logic       prev_valid = 1'b0;

    rr_arbiter_16 dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every new grant must match the next expected owner.
    always @(negedge clk) begin
        logic [15:0] onehot;
        logic [3:0]  exp_id;
        if (grant_valid && !prev_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: grant_id=%0d granted, none expected", grant_id);
            end else begin
                exp_id = exp_q.pop_front();
                onehot = 16'h0001 << exp_id;
                if (grant_id !== exp_id || grant !== onehot) begin
                    tests_failed++;
                    $display("FAIL sb_grant: got id=%0d grant=%h, expected id=%0d grant=%h",
                             grant_id, grant, exp_id, onehot);
                end
            end
        end
        prev_valid <= grant_valid;
    end

    task automatic wait_grant(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (!grant_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!grant_valid) begin
            tests_failed++;
            $display("FAIL %s_wait: no grant within %0d cycles, grant_valid=%b required 1", name, limit, grant_valid);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '0; done = 1'b0; enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 16'hFFFF; enable = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (grant !== 16'h0 || grant_valid !== 1'b0 || grant_id !== 4'd0 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: grant=%h valid=%b id=%0d timeout=%b, required all 0",
                     grant, grant_valid, grant_id, timeout);
        end
        reset = 1'b0; req = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        exp_q.push_back(4'd4);
        req = 16'h0010; enable = 1'b1;
        @(negedge clk);
        tests_run++;
        if (grant !== 16'h0010 || grant_id !== 4'd4 || grant_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_latency: grant=%h id=%0d valid=%b, required 0010/4/1", grant, grant_id, grant_valid);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0; req = '0;
        tests_run++;
        if (grant !== 16'h0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_release: grant=%h valid=%b timeout=%b, required 0/0/0", grant, grant_valid, timeout);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int gap;
        do_reset();
        for (int k = 0; k <= 16; k++) exp_q.push_back(4'(15 - k));
        req = 16'hFFFF; enable = 1'b1;
        for (int g = 0; g <= 16; g++) begin
            wait_grant("b2b", 10);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            if (g == 16) req = '0;
            gap = 0;
            while (!grant_valid && gap < 8) begin
                gap++;
                @(negedge clk);
            end
            if (g < 16) begin
                tests_run++;
                if (gap !== 2) begin
                    tests_failed++;
                    $display("FAIL b2b_gap: grant %0d gap=%0d cycles, required 2", g, gap);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int held = 0;
        do_reset();
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd0);
        req = 16'h0001; enable = 1'b1;
        wait_grant("tmo", 10);
        while (grant_valid && held < 100) begin
            held++;
            @(negedge clk);
        end
        tests_run++;
        if (held !== 64) begin
            tests_failed++;
            $display("FAIL tmo_hold: held %0d cycles, required 64", held);
        end
        tests_run++;
        if (timeout !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_pulse: timeout=%b in gap, required 1", timeout);
        end
        @(negedge clk);
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_width: timeout=%b after gap, required 0", timeout);
        end
        wait_grant("tmo_regrant", 5);
        req = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (timeout !== 1'b0 || grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_reqdrop: timeout=%b valid=%b after req drop, required 0/0", timeout, grant_valid);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        exp_q.push_back(4'd7);
        req = 16'h0080; enable = 1'b1;
        wait_grant("rst7", 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (grant !== 16'h0 || grant_valid !== 1'b0 || grant_id !== 4'd0 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid: grant=%h valid=%b id=%0d timeout=%b, required all 0",
                     grant, grant_valid, grant_id, timeout);
        end
        exp_q.push_back(4'd15);
        req = 16'hFFFF;
        wait_grant("rst15", 5);
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_enable();
        int bad = 0;
        do_reset();
        req = 16'h0300; enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (grant_valid) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL en_off: %0d granted cycles with enable=0, required 0", bad);
        end
        exp_q.push_back(4'd9);
        enable = 1'b1;
        wait_grant("en_on", 5);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd9 || grant !== 16'h0200) begin
            tests_failed++;
            $display("FAIL en_hold: valid=%b id=%0d grant=%h, required 1/9/0200", grant_valid, grant_id, grant);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        bad = 0;
        repeat (4) begin
            if (grant_valid) bad++;
            @(negedge clk);
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL en_release: %0d granted cycles after done with enable=0, required 0", bad);
        end
        req = '0;
    endtask

    // Grant must always equal grant_valid shifted to grant_id.
    always @(negedge clk) begin
        logic [15:0] shaped;
        shaped = {15'b0, grant_valid} << grant_id;
        if (!reset) begin
            tests_run++;
            if (grant !== shaped) begin
                tests_failed++;
                $display("FAIL inv_onehot: grant=%h, required %h", grant, shaped);
            end
        end
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_reset_mid_grant();
        test_enable();
        repeat (2) @(negedge clk);
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL sb_drain: %0d expected grants never seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
